// File: rtl/aes_encrypt_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes_encrypt_scheduler: round-robin, valid/ready front end for one iterative AES-128 core
// Revision: 1.0
// ----------------------------------------------------------------------------
module aes_encrypt_scheduler #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0_valid,
  input  logic [0:127]            req0_msg,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [0:127]            req1_msg,
  output logic                    req1_ready,
  input  logic [0:32*NK*(NR+1)-1] keySchedule,
  output logic [0:127]            cipher,
  output logic                    out_id,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic [0:3]              round
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_RUN_ROUND = 4'(NR - 1);

  state_t       state;
  state_t       next_state;
  logic [0:127] blk;
  logic         id_reg;
  logic         last_grant;
  logic         grant;
  logic         accept;
  logic [0:127] rk [0:NR];

  for (genvar g = 0; g <= NR; g++) begin : g_rk
    assign rk[g] = keySchedule[32*NK*g +: 128];
  end

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // S-box computed as GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
    x2   = gmul(x, x);
    x4   = gmul(x2, x2);
    x8   = gmul(x4, x4);
    x16  = gmul(x8, x8);
    x32  = gmul(x16, x16);
    x64  = gmul(x32, x32);
    x128 = gmul(x64, x64);
    inv  = gmul(gmul(gmul(x2, x4), gmul(x8, x16)), gmul(gmul(x32, x64), x128));
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [0:127] aes_round(input logic [0:127] s, input logic [0:127] k,
                                             input logic final_round);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [0:127] o;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s[8*i +: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      if (final_round)
        o[32*c +: 32] = {a0, a1, a2, a3};
      else
        o[32*c +: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                         a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                         a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                         xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o ^ k;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    grant      = 1'b0;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the requester that did not win last time is served.
        grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        accept     = req0_valid || req1_valid;
        req0_ready = req0_valid && !grant;
        req1_ready = req1_valid && grant;
        if (accept) next_state = RUN;
      end
      RUN:     if (round == LAST_RUN_ROUND) next_state = LAST;
      LAST:    next_state = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk        <= '0;
      id_reg     <= 1'b0;
      last_grant <= 1'b1;
      round      <= 4'd0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          blk        <= (grant ? req1_msg : req0_msg) ^ rk[0];
          id_reg     <= grant;
          last_grant <= grant;
          round      <= 4'd1;
        end
        RUN: begin
          blk   <= aes_round(blk, rk[round], 1'b0);
          round <= round + 4'd1;
        end
        LAST: begin
          blk   <= aes_round(blk, rk[NR], 1'b1);
          round <= 4'd0;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign cipher = (state == DONE) ? blk : '0;
  assign out_id = (state == DONE) && id_reg;

endmodule
`default_nettype wire

// File: tb/tb_aes_encrypt_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_aes_encrypt_scheduler: directed + random bench with a transaction-level AES model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_aes_encrypt_scheduler;

  localparam int NR  = 10;
  localparam int KSW = 128 * (NR + 1);

  localparam logic [0:127] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] PT2 = 128'h54776F204F6E65204E696E652054776F;
  localparam logic [0:127] K2  = 128'h5468617473206D79204B756E67204675;
  localparam logic [0:127] CT2 = 128'h29C3505F571420F6402299B31A02D73A;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           req0_valid = 1'b0;
  logic [0:127]   req0_msg = '0;
  logic           req0_ready;
  logic           req1_valid = 1'b0;
  logic [0:127]   req1_msg = '0;
  logic           req1_ready;
  logic [0:KSW-1] ks = '0;
  logic [0:127]   cipher;
  logic           out_id;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           busy;
  logic [0:3]     round;

  always #5 clk = ~clk;

  aes_encrypt_scheduler #(.NK(4), .NR(NR)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_msg    (req0_msg),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_msg    (req1_msg),
    .req1_ready  (req1_ready),
    .keySchedule (ks),
    .cipher      (cipher),
    .out_id      (out_id),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .round       (round)
  );

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [7:0] sbox_t [256];

  // Transaction-level model: idle, or a block accepted m_cnt edges ago.
  bit           m_busy = 1'b0;
  int           m_cnt = 0;
  logic [0:127] m_res = '0;
  bit           m_id = 1'b0;
  bit           m_lg = 1'b1;
  int           acc_time[$];
  bit           acc_id[$];
  int           hs_time[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %b required %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box table built by walking generator 3 and its inverse.
  function automatic void init_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
      sbox_t[p] = x;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endfunction

  function automatic logic [0:KSW-1] key_expand(input logic [0:127] key);
    logic [31:0]    w [4*(NR+1)];
    logic [31:0]    t;
    logic [7:0]     rc;
    logic [0:KSW-1] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 4*(NR+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 4*(NR+1); i++) o[32*i +: 32] = w[i];
    return o;
  endfunction

  function automatic logic [0:127] aes_model(input logic [0:127] pt, input logic [0:KSW-1] k);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [0:127] o;
    for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ k[8*i +: 8];
    for (int r = 1; r <= NR; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[4*c+w] = t[4*((c+w)%4)+w];
      if (r != NR) begin
        for (int c = 0; c < 4; c++) begin
          for (int w = 0; w < 4; w++) a[w] = s[4*c+w];
          s[4*c]   = xt(a[0]) ^ xt(a[1]) ^ a[1] ^ a[2] ^ a[3];
          s[4*c+1] = a[0] ^ xt(a[1]) ^ xt(a[2]) ^ a[2] ^ a[3];
          s[4*c+2] = a[0] ^ a[1] ^ xt(a[2]) ^ xt(a[3]) ^ a[3];
          s[4*c+3] = xt(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xt(a[3]);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[128*r + 8*i +: 8];
    end
    for (int i = 0; i < 16; i++) o[8*i +: 8] = s[i];
    return o;
  endfunction

  function automatic bit grant_of(input bit v0, input bit v1, input bit lg);
    return (v0 && v1) ? !lg : v1;
  endfunction

  function automatic logic [0:127] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_lg   <= 1'b1;
      m_id   <= 1'b0;
    end else if (!m_busy) begin
      if (req0_valid || req1_valid) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        m_id   <= grant_of(req0_valid, req1_valid, m_lg);
        m_lg   <= grant_of(req0_valid, req1_valid, m_lg);
        m_res  <= aes_model(grant_of(req0_valid, req1_valid, m_lg) ? req1_msg : req0_msg, ks);
        acc_time.push_back(cyc);
        acc_id.push_back(grant_of(req0_valid, req1_valid, m_lg));
      end
    end else if (m_cnt < NR) begin
      m_cnt <= m_cnt + 1;
    end else if (out_ready) begin
      m_busy <= 1'b0;
      hs_time.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk1("busy", busy, m_busy);
      chk1("out_valid", out_valid, m_busy && m_cnt == NR);
      chk_int("round", int'(round), (m_busy && m_cnt < NR) ? m_cnt + 1 : 0);
      chk1("req0_ready", req0_ready, !m_busy && req0_valid && !grant_of(req0_valid, req1_valid, m_lg));
      chk1("req1_ready", req1_ready, !m_busy && req1_valid && grant_of(req0_valid, req1_valid, m_lg));
      if (m_busy && m_cnt == NR) begin
        chk("cipher", cipher, m_res);
        chk1("out_id", out_id, m_id);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accepts(input int n);
    int b = 0;
    while (acc_time.size() < n && b < 100) begin
      tick();
      b++;
    end
    chk_int("accept_count", acc_time.size(), n);
  endtask

  task automatic wait_out(output int t);
    int b = 0;
    @(negedge clk);
    while (!out_valid && b < 100) begin
      @(negedge clk);
      b++;
    end
    chk1("out_valid_seen", out_valid, 1'b1);
    t = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t required below 1000000", $time);
    $fatal(1);
  end

  initial begin
    int           a, t, base, r, n_acc, n_out;
    logic [0:127] c0, exp_ct;
    logic         id0;

    init_sbox();
    chk("model_fips", aes_model(PT1, key_expand(K1)), CT1);
    chk("model_v2", aes_model(PT2, key_expand(K2)), CT2);
    ks = key_expand(K1);
    chk("ks_round10", ks[128*NR +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    repeat (2) @(posedge clk);
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_req0_ready", req0_ready, 1'b0);
    chk1("rst_req1_ready", req1_ready, 1'b0);
    chk1("rst_out_id", out_id, 1'b0);
    chk("rst_cipher", cipher, '0);
    chk_int("rst_round", int'(round), 0);
    reset = 1'b0;

    // FIPS-197 single block from requester 0
    out_ready  = 1'b1;
    req0_msg   = PT1;
    req0_valid = 1'b1;
    wait_accepts(1);
    req0_valid = 1'b0;
    a = acc_time[0];
    wait_out(t);
    chk_int("fips_latency", t - 1 - a, NR);
    chk("fips_cipher", cipher, CT1);
    chk1("fips_id", out_id, 1'b0);
    @(negedge clk);
    chk1("fips_valid_one_cycle", out_valid, 1'b0);

    // Requester 1 alone with a different key
    ks         = key_expand(K2);
    req1_msg   = PT2;
    req1_valid = 1'b1;
    wait_accepts(2);
    req1_valid = 1'b0;
    wait_out(t);
    chk("r1_cipher", cipher, CT2);
    chk1("r1_id", out_id, 1'b1);

    // Contention: both valid continuously
    base       = acc_time.size();
    req0_msg   = rand128();
    req1_msg   = rand128();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_accepts(base + k + 1);
      if (acc_id[acc_id.size()-1]) req1_msg = rand128();
      else                         req0_msg = rand128();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int k = 0; k < 4; k++) chk1("contention_grant", acc_id[base+k], (k % 2) == 1);
    for (int k = 1; k < 4; k++) chk_int("contention_gap", acc_time[base+k] - acc_time[base+k-1], NR + 2);
    repeat (NR + 4) tick();

    // Back-pressure with requester 1 waiting
    out_ready  = 1'b0;
    req0_msg   = rand128();
    req0_valid = 1'b1;
    wait_accepts(acc_time.size() + 1);
    req0_valid = 1'b0;
    req1_msg   = rand128();
    req1_valid = 1'b1;
    wait_out(t);
    c0  = cipher;
    id0 = out_id;
    repeat (5) begin
      @(negedge clk);
      chk("bp_cipher_stable", cipher, c0);
      chk1("bp_id_stable", out_id, id0);
      chk1("bp_valid_held", out_valid, 1'b1);
      chk1("bp_req1_ready", req1_ready, 1'b0);
    end
    n_acc     = acc_time.size();
    r         = cyc;
    out_ready = 1'b1;
    wait_accepts(n_acc + 1);
    req1_valid = 1'b0;
    chk_int("bp_handshake_edge", hs_time[hs_time.size()-1], r);
    chk_int("bp_accept_edge", acc_time[acc_time.size()-1], r + 1);
    chk1("bp_accept_id", acc_id[acc_id.size()-1], 1'b1);
    wait_out(t);
    repeat (2) tick();

    // Reset in the middle of a block
    req0_msg   = rand128();
    req0_valid = 1'b1;
    wait_accepts(acc_time.size() + 1);
    req0_valid = 1'b0;
    for (int b = 0; b < 20 && round != 4'd5; b++) @(negedge clk);
    chk_int("rst_mid_round", int'(round), 5);
    reset = 1'b1;
    #1;
    chk1("rst_mid_out_valid", out_valid, 1'b0);
    chk1("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_cipher", cipher, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n_out = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) n_out++;
    end
    chk_int("rst_no_output", n_out, 0);
    req0_msg   = rand128();
    req1_msg   = rand128();
    exp_ct     = aes_model(req0_msg, ks);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    wait_accepts(acc_time.size() + 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk1("rst_tie_grant", acc_id[acc_id.size()-1], 1'b0);
    wait_out(t);
    chk("rst_after_cipher", cipher, exp_ct);

    // Valid pulses while busy are not accepted
    tick();
    req0_msg   = rand128();
    req0_valid = 1'b1;
    wait_accepts(acc_time.size() + 1);
    req0_valid = 1'b0;
    repeat (2) tick();
    repeat (3) begin
      req0_valid = 1'b1;
      #1;
      chk1("busy_reject_ready", req0_ready, 1'b0);
      tick();
    end
    req0_valid = 1'b0;
    n_acc = acc_time.size();
    wait_out(t);
    n_out = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) n_out++;
    end
    chk_int("busy_no_extra_out", n_out, 0);
    chk_int("busy_no_extra_accept", acc_time.size(), n_acc);

    // Randomized traffic
    tick();
    for (int i = 0; i < 500; i++) begin
      if (!m_busy && $urandom_range(0, 7) == 0) ks = key_expand(rand128());
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) req0_msg = rand128();
      if ($urandom_range(0, 3) == 0) req1_msg = rand128();
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready  = 1'b1;
    repeat (NR + 6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
